// File: rtl/bias_load_ctrl_if.sv
// rtl/bias_load_ctrl_if.sv - bias word / request inputs and serial chain outputs of bias_load_ctrl
interface bias_load_ctrl_if #(
  parameter int NUM_BIASES = 4,
  parameter int BIAS_WIDTH = 24
);
  logic [BIAS_WIDTH-1:0] bias [0:NUM_BIASES-1];
  logic                  load_req;
  logic                  bias_sclk;
  logic                  bias_sdata;
  logic                  bias_latch;
  logic                  busy;
  logic                  done;

  modport master (
    output bias, load_req,
    input  bias_sclk, bias_sdata, bias_latch, busy, done
  );

  modport slave (
    input  bias, load_req,
    output bias_sclk, bias_sdata, bias_latch, busy, done
  );
endinterface

// File: rtl/bias_load_ctrl.sv
// rtl/bias_load_ctrl.sv - snapshots bias words and shifts them serially into the bias generator
module bias_load_ctrl #(
  parameter int NUM_BIASES = 4,
  parameter int BIAS_WIDTH = 24,
  parameter int CLK_DIV    = 2
) (
  input  logic         clk,
  input  logic         rst,
  bias_load_ctrl_if.slave bus
);
  localparam int TOTAL = NUM_BIASES * BIAS_WIDTH;
  localparam int BIT_W = $clog2(TOTAL);
  localparam int PH_W  = $clog2(2 * CLK_DIV);

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(TOTAL - 1);
  localparam logic [PH_W-1:0]  PH_HI     = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  PH_END    = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  LATCH_END = PH_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  state_t             state_q, state_d;
  logic [TOTAL-1:0]   shadow_q, shadow_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic               pending_q, pending_d;
  logic               sclk_q, sclk_d;
  logic               sdata_q, sdata_d;
  logic               latch_q, latch_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [TOTAL-1:0]   bias_flat;
  logic [BIT_W-1:0]   bit_dec;
  logic [PH_W-1:0]    ph_inc;
  logic               launch;

  // bias[NUM_BIASES-1] lands in the top bits so the chain shifts from the MSB down
  always_comb begin
    bias_flat = '0;
    for (int i = 0; i < NUM_BIASES; i++) begin
      bias_flat[i*BIAS_WIDTH +: BIAS_WIDTH] = bus.bias[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bit_d     = bit_q;
    ph_d      = ph_q;
    pending_d = pending_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    latch_d   = latch_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    launch    = 1'b0;
    bit_dec   = bit_q - 1'b1;
    ph_inc    = ph_q + 1'b1;

    if (bus.load_req && state_q != IDLE) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.load_req || pending_q) begin
          launch = 1'b1;
        end
      end
      SHIFT: begin
        if (ph_q == PH_END) begin
          ph_d   = '0;
          sclk_d = 1'b0;
          if (bit_q == '0) begin
            state_d = LATCH;
            sdata_d = 1'b0;
            latch_d = 1'b1;
          end else begin
            bit_d   = bit_dec;
            sdata_d = shadow_q[bit_dec];
          end
        end else begin
          ph_d   = ph_inc;
          sclk_d = (ph_inc >= PH_HI);
        end
      end
      LATCH: begin
        if (ph_q == LATCH_END) begin
          state_d = DONE;
          latch_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ph_d = ph_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (pending_q) begin
          launch = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request coinciding with the launch edge is covered by this snapshot
    if (launch) begin
      state_d   = SHIFT;
      shadow_d  = bias_flat;
      pending_d = 1'b0;
      bit_d     = BIT_LAST;
      ph_d      = '0;
      sclk_d    = 1'b0;
      sdata_d   = bias_flat[TOTAL-1];
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      bit_q     <= '0;
      ph_q      <= '0;
      pending_q <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bit_q     <= bit_d;
      ph_q      <= ph_d;
      pending_q <= pending_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.bias_sclk  = sclk_q;
  assign bus.bias_sdata = sdata_q;
  assign bus.bias_latch = latch_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_bias_load_ctrl.sv
// tb/tb_bias_load_ctrl.sv - self-checking bench for bias_load_ctrl (CLK_DIV=2 and CLK_DIV=1 builds)
module tb_bias_load_ctrl;
  localparam int NB    = 4;
  localparam int BW    = 24;
  localparam int TOTAL = NB * BW;

  typedef logic [BW-1:0] words_t [0:NB-1];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bias_load_ctrl_if #(.NUM_BIASES(NB), .BIAS_WIDTH(BW)) ifa ();
  bias_load_ctrl_if #(.NUM_BIASES(NB), .BIAS_WIDTH(BW)) ifb ();

  bias_load_ctrl #(.NUM_BIASES(NB), .BIAS_WIDTH(BW), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  bias_load_ctrl #(.NUM_BIASES(NB), .BIAS_WIDTH(BW), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  // Observers: sample every cycle on the falling edge
  logic             pa_sclk = 1'b0, pa_sdata = 1'b0, pa_busy = 1'b0;
  logic [TOTAL-1:0] cap_a = '0;
  int               rise_a = 0, latch_a = 0, done_a = 0, done_cyc_a = 0, stab_a = 0, busy_rise_a = 0;

  always @(negedge clk) begin
    if (ifa.bias_sclk && !pa_sclk) begin
      cap_a = {cap_a[TOTAL-2:0], ifa.bias_sdata};
      rise_a++;
    end
    if (ifa.bias_sclk && pa_sclk && ifa.bias_sdata !== pa_sdata) stab_a++;
    if (ifa.bias_latch) latch_a++;
    if (ifa.done) begin
      done_a++;
      done_cyc_a = cyc;
    end
    if (ifa.busy && !pa_busy) busy_rise_a = cyc;
    pa_sclk  = ifa.bias_sclk;
    pa_sdata = ifa.bias_sdata;
    pa_busy  = ifa.busy;
  end

  logic pb_sclk = 1'b0, pb_busy = 1'b0, pb_latch = 1'b0;
  int   rise_b = 0, ones_b = 0, latch_b = 0, done_b = 0, done_cyc_b = 0, tog_b = 0;

  always @(negedge clk) begin
    if (ifb.bias_sclk && !pb_sclk) begin
      rise_b++;
      if (ifb.bias_sdata) ones_b++;
    end
    if (ifb.bias_latch) latch_b++;
    if (ifb.done) begin
      done_b++;
      done_cyc_b = cyc;
    end
    if (ifb.busy && !ifb.bias_latch && pb_busy && !pb_latch && ifb.bias_sclk === pb_sclk) tog_b++;
    pb_sclk  = ifb.bias_sclk;
    pb_busy  = ifb.busy;
    pb_latch = ifb.bias_latch;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [4:0] outs_a();
    return {ifa.bias_sclk, ifa.bias_sdata, ifa.bias_latch, ifa.busy, ifa.done};
  endfunction

  function automatic logic [4:0] outs_b();
    return {ifb.bias_sclk, ifb.bias_sdata, ifb.bias_latch, ifb.busy, ifb.done};
  endfunction

  task automatic pulse_a(output int start);
    step();
    ifa.load_req = 1'b1;
    start = cyc;
    step();
    ifa.load_req = 1'b0;
  endtask

  task automatic drive_a(input words_t w);
    for (int i = 0; i < NB; i++) ifa.bias[i] = w[i];
  endtask

  task automatic rand_words(output words_t w);
    for (int i = 0; i < NB; i++) w[i] = BW'($urandom);
  endtask

  task automatic wait_done_a(input string tag, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_a >= target) break;
      step();
    end
    check({tag, "_done_seen"}, done_a, target);
  endtask

  // Reference: highest word first, MSB first, as a flat bit stream
  task automatic check_frame_a(input string tag, input words_t m);
    logic [TOTAL-1:0] e;
    e = '0;
    for (int w = NB - 1; w >= 0; w--)
      for (int b = BW - 1; b >= 0; b--)
        e = {e[TOTAL-2:0], m[w][b]};
    for (int w = 0; w < NB; w++)
      check($sformatf("%s_seg%0d", tag, w), cap_a[w*BW +: BW], e[w*BW +: BW]);
  endtask

  initial begin
    words_t w1, w2;
    int s, r0, l0, st0, d0, d1, bad;

    rst = 1'b1;
    ifa.load_req = 1'b0;
    ifb.load_req = 1'b0;
    for (int i = 0; i < NB; i++) begin
      ifa.bias[i] = '0;
      ifb.bias[i] = '0;
    end
    steps(3);
    check("reset_outs_a", outs_a(), 5'b0);
    check("reset_outs_b", outs_b(), 5'b0);
    rst = 1'b0;
    steps(2);

    // T1: directed frame
    w1[0] = 24'h000AAA; w1[1] = 24'h000BBB; w1[2] = 24'h000CCC; w1[3] = 24'h000DDD;
    drive_a(w1);
    r0 = rise_a; l0 = latch_a; st0 = stab_a; d0 = done_a;
    pulse_a(s);
    check("t1_busy_first", busy_rise_a, s + 1);
    wait_done_a("t1", d0 + 1, 600);
    check_frame_a("t1", w1);
    check("t1_sclk_rises", rise_a - r0, TOTAL);
    check("t1_latch_width", latch_a - l0, 2);
    check("t1_sdata_stable", stab_a - st0, 0);
    check("t1_done_cycle", done_cyc_a, s + 1 + TOTAL * 4 + 2);
    step();
    check("t1_idle_outs", outs_a(), 5'b0);

    // T2: bias change after start must not reach the frame
    rand_words(w1);
    drive_a(w1);
    d0 = done_a;
    pulse_a(s);
    steps(9);
    ifa.bias[0] = 24'hFFFFFF;
    wait_done_a("t2", d0 + 1, 600);
    check_frame_a("t2", w1);

    // T3: three requests during a frame coalesce into one extra frame
    rand_words(w1);
    drive_a(w1);
    d0 = done_a;
    pulse_a(s);
    steps(20);
    for (int k = 0; k < 3; k++) begin
      ifa.load_req = 1'b1;
      step();
      ifa.load_req = 1'b0;
      steps(15);
    end
    rand_words(w2);
    drive_a(w2);
    wait_done_a("t3a", d0 + 1, 600);
    d1 = done_cyc_a;
    check_frame_a("t3a", w1);
    wait_done_a("t3b", d0 + 2, 600);
    check("t3_busy_after_done", busy_rise_a, d1 + 1);
    check_frame_a("t3b", w2);
    steps(500);
    check("t3_done_total", done_a - d0, 2);
    check("t3_idle_busy", ifa.busy, 1'b0);

    // T4: reset mid-frame
    rand_words(w1);
    drive_a(w1);
    r0 = rise_a;
    pulse_a(s);
    for (int i = 0; i < 400; i++) begin
      if (rise_a - r0 >= 40) break;
      step();
    end
    check("t4_reached_bit40", rise_a - r0, 40);
    rst = 1'b1;
    #1;
    check("t4_async_outs", outs_a(), 5'b0);
    steps(3);
    rst = 1'b0;
    d0 = done_a;
    steps(500);
    check("t4_no_done", done_a - d0, 0);
    rand_words(w1);
    drive_a(w1);
    d0 = done_a;
    pulse_a(s);
    wait_done_a("t4", d0 + 1, 600);
    check_frame_a("t4", w1);
    check("t4_done_cycle", done_cyc_a, s + 1 + TOTAL * 4 + 2);

    // Random frames against the reference stream
    for (int f = 0; f < 3; f++) begin
      rand_words(w1);
      drive_a(w1);
      r0 = rise_a; d0 = done_a;
      pulse_a(s);
      wait_done_a($sformatf("rnd%0d", f), d0 + 1, 600);
      check_frame_a($sformatf("rnd%0d", f), w1);
      check($sformatf("rnd%0d_rises", f), rise_a - r0, TOTAL);
    end

    // T5: CLK_DIV=1 build, all ones
    for (int i = 0; i < NB; i++) ifb.bias[i] = '1;
    step();
    ifb.load_req = 1'b1;
    s = cyc;
    step();
    ifb.load_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_b >= 1) break;
      step();
    end
    check("t5_done_seen", done_b, 1);
    check("t5_rises", rise_b, TOTAL);
    check("t5_ones", ones_b, TOTAL);
    check("t5_latch_width", latch_b, 1);
    check("t5_toggle_errs", tog_b, 0);
    check("t5_done_cycle", done_cyc_b, s + 1 + TOTAL * 2 + 1);

    // T6: long idle
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (outs_a() !== 5'b0) bad++;
    end
    check("t6_idle_quiet", bad, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
